// File: rtl/substitution_layer_seq.sv
// substitution_layer_seq -- iterative, handshaked Ascon substitution layer.
//
// Applies the 5-bit Ascon S-box to LANES bit-columns of the 320-bit state per
// clock, working in place on an internal state register. A state is accepted in
// IDLE, substituted over 64/LANES RUN cycles, then held in DONE until the
// downstream handshake completes.
//
// Parameters:
//   LANES            columns per cycle; one of 1, 2, 4, 8, 16, 32, 64
// Optional feature macro:
//   SUBST_LAYER_INV_EN  adds the inv_i port and the inverse S-box table
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     input state offered
//   in_ready_o     block can accept a state (high only in IDLE)
//   state_array_i  input state, word Sk at index k
//   inv_i          select inverse S-box for this transaction (optional)
//   out_valid_o    result available (high only in DONE)
//   out_ready_i    downstream accepts result
//   state_array_o  result state (the working register)

package ascon_pkg;
    localparam int WORD_WIDTH = 64;
    // Index k holds word Sk; bit j of each word forms column j.
    typedef logic [4:0][WORD_WIDTH-1:0] ascon_state_t;
endpackage

module substitution_layer_seq
    import ascon_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  ascon_state_t state_array_i,
`ifdef SUBST_LAYER_INV_EN
    input  logic         inv_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_array_o
);

    localparam int SLICES  = 64 / LANES;
    localparam int CNT_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int LANE_SH = $clog2(LANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
            LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
            $fatal(1, "substitution_layer_seq: LANES must be a power of two from 1 to 64");
        end
    endgenerate

    localparam logic [4:0] FWD_TAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

`ifdef SUBST_LAYER_INV_EN
    localparam logic [4:0] INV_TAB [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };
    logic inv_q, inv_d;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ascon_state_t     work_q, work_d;

    // First column of the slice handled this cycle (cnt * LANES).
    logic [5:0] base;
    assign base = 6'(32'(cnt_q) << LANE_SH);

    logic [4:0] x_lane [LANES];
    logic [4:0] y_lane [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [5:0] col;
            assign col = base + 6'(gi);
            // S0 supplies the MSB of the column value.
            assign x_lane[gi] = {work_q[0][col], work_q[1][col], work_q[2][col],
                                 work_q[3][col], work_q[4][col]};
`ifdef SUBST_LAYER_INV_EN
            assign y_lane[gi] = inv_q ? INV_TAB[x_lane[gi]] : FWD_TAB[x_lane[gi]];
`else
            assign y_lane[gi] = FWD_TAB[x_lane[gi]];
`endif
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        work_d = work_q;
`ifdef SUBST_LAYER_INV_EN
        inv_d  = inv_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    work_d = state_array_i;
                    cnt_d  = '0;
`ifdef SUBST_LAYER_INV_EN
                    inv_d  = inv_i;
`endif
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    work_d[0][base + 6'(i)] = y_lane[i][4];
                    work_d[1][base + 6'(i)] = y_lane[i][3];
                    work_d[2][base + 6'(i)] = y_lane[i][2];
                    work_d[3][base + 6'(i)] = y_lane[i][1];
                    work_d[4][base + 6'(i)] = y_lane[i][0];
                end
                // Hold the counter on the final slice rather than wrapping.
                if (cnt_q == CNT_LAST) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
`ifdef SUBST_LAYER_INV_EN
            inv_q  <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
`ifdef SUBST_LAYER_INV_EN
            inv_q  <= inv_d;
`endif
        end
    end

    assign in_ready_o    = (fsm_q == IDLE);
    assign out_valid_o   = (fsm_q == DONE);
    assign state_array_o = work_q;

endmodule

// File: tb/tb_substitution_layer_seq.sv
// Testbench for substitution_layer_seq: three instances (LANES = 8, 1, 64) are
// checked every cycle against a transaction-level model that computes the
// S-box layer with the bitsliced Ascon equations and tracks the handshake
// timing as "accept, wait 64/LANES cycles, hold until taken".
module tb_substitution_layer_seq;
    import ascon_pkg::*;

`ifdef SUBST_LAYER_INV_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    localparam logic [4:0] TAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         inv       [3];
    logic         out_valid [3];
    logic         out_ready [3];
    ascon_state_t state_in  [3];
    ascon_state_t state_out [3];

    always #5 clk = ~clk;

    substitution_layer_seq #(.LANES(8)) u_l8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .state_array_i(state_in[0]),
`ifdef SUBST_LAYER_INV_EN
        .inv_i(inv[0]),
`endif
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .state_array_o(state_out[0]));

    substitution_layer_seq #(.LANES(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .state_array_i(state_in[1]),
`ifdef SUBST_LAYER_INV_EN
        .inv_i(inv[1]),
`endif
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .state_array_o(state_out[1]));

    substitution_layer_seq #(.LANES(64)) u_l64 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .state_array_i(state_in[2]),
`ifdef SUBST_LAYER_INV_EN
        .inv_i(inv[2]),
`endif
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .state_array_o(state_out[2]));

    // ---------------- reference model ----------------
    logic [4:0] inv_tab [32];

    function automatic int lat_of(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 64 : 1);
    endfunction

    // Bitsliced Ascon S-box equations applied to all 64 columns at once.
    function automatic ascon_state_t eq_fwd(input ascon_state_t s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        ascon_state_t r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic ascon_state_t model_sub(input ascon_state_t s, input logic iv);
        ascon_state_t r;
        logic [4:0] x, y;
        if (!iv) return eq_fwd(s);
        r = '0;
        for (int j = 0; j < 64; j++) begin
            x = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            y = inv_tab[x];
            r[0][j] = y[4]; r[1][j] = y[3]; r[2][j] = y[2]; r[3][j] = y[1]; r[4][j] = y[0];
        end
        return r;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int b = 0; b < 5; b++) s[b] = {$urandom, $urandom};
        return s;
    endfunction

    // Phase: 0 idle, 1 busy, 2 result held.
    int           cyc = 0;
    int           m_phase [3];
    int           m_rem   [3];
    ascon_state_t m_res   [3];
    ascon_state_t m_out   [3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_phase[d] <= 0;
                m_rem[d]   <= 0;
                m_out[d]   <= '0;
            end else if (m_phase[d] == 0) begin
                if (in_valid[d]) begin
                    m_phase[d] <= 1;
                    m_rem[d]   <= lat_of(d);
                    m_res[d]   <= model_sub(state_in[d], INV_ON ? inv[d] : 1'b0);
                end
            end else if (m_phase[d] == 1) begin
                if (m_rem[d] == 1) begin
                    m_phase[d] <= 2;
                    m_out[d]   <= m_res[d];
                end else begin
                    m_rem[d] <= m_rem[d] - 1;
                end
            end else if (out_ready[d]) begin
                m_phase[d] <= 0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int acc_cyc [3];

    task automatic chk(input string nm, input int d, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, got, exp);
        end
    endtask

    task automatic send(input int d, input ascon_state_t s, input logic iv);
        int t;
        state_in[d] = s; inv[d] = iv; in_valid[d] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready[d] && t < 300) begin @(negedge clk); t++; end
        if (!in_ready[d]) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout dut%0d cyc %0d: in_ready stayed 0, expected 1", d, cyc);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        acc_cyc[d] = cyc;
    endtask

    task automatic recv(input int d, output ascon_state_t r, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid[d] && t < 300) begin @(negedge clk); t++; end
        if (!out_valid[d]) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout dut%0d cyc %0d: out_valid stayed 0, expected 1", d, cyc);
        end
        r = state_out[d];
        lat = cyc - acc_cyc[d];
        if (out_ready[d]) begin @(posedge clk); #1; end
    endtask

    ascon_state_t s, r, z, e, cap;
    int lat;
    logic [4:0] y;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1; inv[d] = 1'b0; state_in[d] = '0;
        end
        for (int v = 0; v < 32; v++) begin
            ascon_state_t ts, tr;
            logic [4:0] vv, ty;
            vv = 5'(v);
            for (int b = 0; b < 5; b++) ts[b] = {64{vv[4-b]}};
            tr = eq_fwd(ts);
            ty = {tr[0][0], tr[1][0], tr[2][0], tr[3][0], tr[4][0]};
            inv_tab[ty] = vv;
        end

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    for (int d = 0; d < 3; d++) begin
                        chk("in_ready", d, 320'(in_ready[d]), 320'(m_phase[d] == 0));
                        chk("out_valid", d, 320'(out_valid[d]), 320'(m_phase[d] == 2));
                        if (m_phase[d] != 1) chk("state_out", d, state_out[d], m_out[d]);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset state pinned to literals.
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", d, 320'(in_ready[d]), 320'(1));
            chk("reset_valid", d, 320'(out_valid[d]), 320'(0));
            chk("reset_state", d, state_out[d], '0);
        end
        @(posedge clk); #1;

        // All-zero state: 0 -> 0x04 in every column.
        send(0, '0, 1'b0);
        recv(0, r, lat);
        e = '0; e[2] = '1;
        chk("zero_result", 0, r, e);
        chk("zero_latency", 0, 320'(lat), 320'(8));

        // All-ones state: 0x1f -> 0x17, on every lane width.
        s = '1;
        e = '1; e[1] = '0;
        for (int d = 0; d < 3; d++) begin
            send(d, s, 1'b0);
            recv(d, r, lat);
            chk("ones_result", d, r, e);
            chk("ones_latency", d, 320'(lat), 320'(lat_of(d)));
        end

        // Column 37 sweep against the table literals.
        for (int x = 0; x < 32; x++) begin
            logic [4:0] xv;
            xv = 5'(x);
            s = '0;
            for (int b = 0; b < 5; b++) s[b][37] = xv[4-b];
            send(0, s, 1'b0);
            recv(0, r, lat);
            y = {r[0][37], r[1][37], r[2][37], r[3][37], r[4][37]};
            chk("col37", 0, 320'(y), 320'(TAB[x]));
            for (int b = 0; b < 5; b++) r[b][37] = 1'b0;
            e = '0; e[2] = '1; e[2][37] = 1'b0;
            chk("col37_others", 0, r, e);
        end

        // Backpressure: hold DONE for 10 cycles with a competing input offered.
        out_ready[0] = 1'b0;
        send(0, rand_state(), 1'b0);
        recv(0, cap, lat);
        in_valid[0] = 1'b1;
        state_in[0] = rand_state();
        repeat (10) begin
            @(negedge clk);
            chk("bp_stable", 0, state_out[0], cap);
            chk("bp_valid", 0, 320'(out_valid[0]), 320'(1));
            chk("bp_ready", 0, 320'(in_ready[0]), 320'(0));
        end
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", 0, 320'(in_ready[0]), 320'(1));
        chk("bp_release_valid", 0, 320'(out_valid[0]), 320'(0));
        @(posedge clk); #1;

        // Reset in the third RUN cycle.
        send(0, rand_state(), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 0, 320'(out_valid[0]), 320'(0));
        chk("midrst_state", 0, state_out[0], '0);
        chk("midrst_ready", 0, 320'(in_ready[0]), 320'(1));
        @(posedge clk); #1;
        s = rand_state();
        send(0, s, 1'b0);
        recv(0, r, lat);
        chk("post_reset_result", 0, r, eq_fwd(s));

        // Random states on the narrow and wide instances.
        for (int d = 1; d < 3; d++) begin
            repeat (3) begin
                s = rand_state();
                send(d, s, 1'b0);
                recv(d, r, lat);
                chk("rand_result", d, r, eq_fwd(s));
                chk("rand_latency", d, 320'(lat), 320'(lat_of(d)));
            end
        end

        // Random traffic with random valid/ready on LANES=8.
        repeat (2000) begin
            @(posedge clk); #1;
            in_valid[0]  = 1'($urandom_range(0, 1));
            state_in[0]  = rand_state();
            inv[0]       = INV_ON ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready[0] = ($urandom_range(0, 3) != 0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        inv[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;

`ifdef SUBST_LAYER_INV_EN
        // Inverse of the all-zero state: every column becomes 0x14.
        send(0, '0, 1'b1);
        recv(0, r, lat);
        e = '0; e[0] = '1; e[2] = '1;
        chk("inv_zero", 0, r, e);

        // Forward then inverse round trips.
        repeat (500) begin
            s = rand_state();
            send(0, s, 1'b0);
            recv(0, r, lat);
            send(0, r, 1'b1);
            recv(0, z, lat);
            chk("roundtrip", 0, z, s);
        end
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/substitution_layer_seq.md
# substitution_layer_seq

Iterative, handshaked Ascon substitution layer that applies the 5-bit S-box to LANES bit-columns of the 320-bit state per clock. It replaces the fully combinational substitution layer in area-constrained permutation datapaths, sitting between the constant-addition stage and the linear diffusion layer. The column slice width is a parameter, so one RTL covers 1 to 64 S-box instances. An optional inverse mode supports decryption-side research and self-checking.

## Interface
- LANES, 8, columns processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64; any other value is an elaboration-time $fatal
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  input state offered
- in_ready_o  out  1  block can accept a state
- state_array_i  in  ascon_state_t  input state, words S0..S4 of WORD_WIDTH=64 bits
- inv_i  in  1  select inverse S-box for this transaction (present only with SUBST_LAYER_INV_EN)
- out_valid_o  out  1  result available
- out_ready_i  in  1  downstream accepts result
- state_array_o  out  ascon_state_t  result state (working register)

## Operation
- Column mapping: for column j, x = {S0[j],S1[j],S2[j],S3[j],S4[j]}, S0 the MSB; the result y is written back with the same mapping (y[4]→S0[j] … y[0]→S4[j]).
- Forward S-box table x=0..31: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o: load state_array_i into working register, clear column counter cnt, latch inv_i, go RUN.
- RUN: each cycle substitutes columns [cnt*LANES +: LANES] of all five words in place; cnt increments. When cnt = 64/LANES−1 (this cycle's slice is the last), go DONE next cycle.
- DONE: out_valid_o=1; state_array_o and out_valid_o held stable until out_ready_i. On out_valid_o & out_ready_i go IDLE.
- cnt width: $clog2(64/LANES), minimum 1 bit. No wrap beyond the final slice; cnt clears on each load.
- in_valid_i ignored outside IDLE; no input is dropped silently because in_ready_o=0 there.
- state_array_i, inv_i sampled only at accept; later changes have no effect.

## Timing
- Reset (rst_i=1 at an edge, any state, including mid-RUN): next cycle state IDLE, cnt=0, working register=0, state_array_o=0, out_valid_o=0, in_ready_o=1. An in-flight transaction is discarded.
- Latency: accept at edge k → out_valid_o=1 after edge k+64/LANES (LANES=64: one RUN cycle; LANES=1: 64 RUN cycles).
- Output handshake at edge m → IDLE after m; next accept earliest at edge m+1. Throughput: one state per 64/LANES+2 cycles with out_ready_i held high.
- out_ready_i high while not in DONE has no effect.
- Outputs are registered; no combinational path from inputs to outputs except none (in_ready_o decodes FSM state only).

## Configuration
- SUBST_LAYER_INV_EN defined: inv_i port exists; inv_i=1 latched at accept selects the inverse table (inverse permutation of the forward table, e.g. 04→00, 17→1f); inv_i=0 selects forward.
- Undefined: no inv_i port, forward table only; no inverse logic synthesized.

## Test plan
- All-zero state, LANES=8, out_ready_i=1 → out_valid_o after exactly 8 cycles; S0=0, S1=0, S2=ffffffffffffffff, S3=0, S4=0.
- All-ones state → S0=ffff…ffff, S1=0, S2=S3=S4=ffff…ffff; repeat with LANES=1, 64: identical result, latencies 64 and 1.
- Directed sweep: column 37 set to x=0..31, others zero → column 37 equals table[x], all other columns equal table[0]; compared against equation model.
- Backpressure: out_ready_i=0 for 10 cycles in DONE → out_valid_o and state_array_o stable, in_ready_o=0, new in_valid_i not accepted; release → IDLE next cycle.
- Reset asserted in the 3rd RUN cycle → next cycle out_valid_o=0, state_array_o=0, in_ready_o=1; following transaction produces a correct result.
- SUBST_LAYER_INV_EN: forward then inverse on 500 random states (back to back) → round-trip equals original input; all-zero input with inv_i=1 → each column table⁻¹[0]=0x14 (S0=ffff…ffff, S2=ffff…ffff, others 0).
